// File: rtl/pipe_cla_subtractor_pkg.sv
// Shared widths and elaboration helpers for the pipelined CLA subtractor.
// Other files pull these in with import pipe_cla_subtractor_pkg::*.
package pipe_cla_subtractor_pkg;

    localparam int DEF_ADDER_WIDTH = 24;
    localparam int DEF_CHUNK_WIDTH = 8;
    localparam int DEF_CLA_GROUP   = 4;

    function automatic int stage_count(input int adder_width, input int chunk_width);
        return adder_width / chunk_width;
    endfunction

    // A partial top slice would need its own stage shape, so only exact multiples are legal.
    function automatic bit width_divides(input int adder_width, input int chunk_width);
        return (chunk_width > 0) && ((adder_width % chunk_width) == 0);
    endfunction

    localparam int DEF_NUM_STAGES = stage_count(DEF_ADDER_WIDTH, DEF_CHUNK_WIDTH);
    localparam bit DEF_WIDTH_OK   = width_divides(DEF_ADDER_WIDTH, DEF_CHUNK_WIDTH);

endpackage

// File: rtl/pipe_cla_subtractor_if.sv
// Operand/result stream bundle for pipe_cla_subtractor.
// The master modport is the producer/consumer side; the slave modport is the subtractor.
interface pipe_cla_subtractor_if
    import pipe_cla_subtractor_pkg::*;
#(
    parameter int ADDER_WIDTH = DEF_ADDER_WIDTH
) ();

    // Handshake: a beat moves across either side on a rising edge iff valid && ready at
    // that edge; in_ready is a combinational function of out_valid and out_ready only.
    logic                   in_valid;
    logic                   in_ready;
    logic [ADDER_WIDTH-1:0] a;
    logic [ADDER_WIDTH-1:0] b;
    logic                   bin;
    logic                   out_valid;
    logic                   out_ready;
    logic [ADDER_WIDTH-1:0] diff;
    logic                   bout;
    logic                   zero;

    modport master (
        output in_valid, a, b, bin, out_ready,
        input  in_ready, out_valid, diff, bout, zero
    );

    modport slave (
        input  in_valid, a, b, bin, out_ready,
        output in_ready, out_valid, diff, bout, zero
    );

endinterface

// File: rtl/cla_adder.sv
// Two-level carry-lookahead adder: bit carries ripple inside a GROUP, while group
// carries are resolved by full lookahead across all groups.
module cla_adder #(
    parameter int WIDTH = 8,
    parameter int GROUP = 4
) (
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic [WIDTH-1:0] sum,
    output logic             cout
);

    localparam int NG = (WIDTH + GROUP - 1) / GROUP;
    localparam int PW = NG * GROUP;

    logic [PW-1:0] pa;
    logic [PW-1:0] pb;
    logic [PW-1:0] g;
    logic [PW-1:0] p;
    logic [PW-1:0] s_full;
    logic [PW:0]   c;
    logic [NG-1:0] gg;
    logic [NG-1:0] gp;
    logic [NG:0]   gc;
    logic          run;
    logic          acc;
    logic          prod;

    // Zero padding has p = g = 0, so it neither creates nor passes a carry.
    assign pa = PW'(a);
    assign pb = PW'(b);
    assign g  = pa & pb;
    assign p  = pa ^ pb;

    always_comb begin
        gg = '0;
        gp = '0;
        for (int k = 0; k < NG; k++) begin
            gp[k] = 1'b1;
            for (int i = 0; i < GROUP; i++) begin
                gg[k] = g[k*GROUP+i] | (p[k*GROUP+i] & gg[k]);
                gp[k] = gp[k] & p[k*GROUP+i];
            end
        end
    end

    always_comb begin
        gc    = '0;
        gc[0] = cin;
        run   = 1'b0;
        acc   = 1'b0;
        prod  = 1'b0;
        for (int k = 0; k < NG; k++) begin
            run = cin;
            for (int j = 0; j <= k; j++) begin
                run = run & gp[j];
            end
            acc = run;
            for (int j = 0; j <= k; j++) begin
                prod = gg[j];
                for (int m = j + 1; m <= k; m++) begin
                    prod = prod & gp[m];
                end
                acc = acc | prod;
            end
            gc[k+1] = acc;
        end
    end

    always_comb begin
        c = '0;
        for (int k = 0; k < NG; k++) begin
            c[k*GROUP] = gc[k];
            for (int i = 0; i < GROUP - 1; i++) begin
                c[k*GROUP+i+1] = g[k*GROUP+i] | (p[k*GROUP+i] & c[k*GROUP+i]);
            end
        end
        c[PW] = gc[NG];
    end

    assign s_full = p ^ c[PW-1:0];
    assign sum    = s_full[WIDTH-1:0];
    assign cout   = c[WIDTH];

endmodule

// File: rtl/pipe_cla_subtractor_sub_chunk_stage.sv
// One subtractor slice: a_slice + ~b_slice + cin on the shared CLA, carry out exposed
// so the caller can register it as the borrow for the next slice.
module pipe_cla_subtractor_sub_chunk_stage
    import pipe_cla_subtractor_pkg::*;
#(
    parameter int CHUNK_WIDTH = DEF_CHUNK_WIDTH
) (
    input  logic [CHUNK_WIDTH-1:0] a_slice,
    input  logic [CHUNK_WIDTH-1:0] b_slice,
    input  logic                   cin,
    output logic [CHUNK_WIDTH-1:0] sum,
    output logic                   cout
);

    logic [CHUNK_WIDTH-1:0] b_inv;

    assign b_inv = ~b_slice;

    cla_adder #(
        .WIDTH (CHUNK_WIDTH),
        .GROUP (DEF_CLA_GROUP)
    ) u_cla (
        .a    (a_slice),
        .b    (b_inv),
        .cin  (cin),
        .sum  (sum),
        .cout (cout)
    );

endmodule

// File: rtl/pipe_cla_subtractor.sv
// Pipelined subtractor diff = a - b - bin, one CHUNK_WIDTH slice per stage with the
// borrow registered between stages and a single advance enable stalling the whole pipe.
module pipe_cla_subtractor
    import pipe_cla_subtractor_pkg::*;
#(
    parameter int ADDER_WIDTH = DEF_ADDER_WIDTH,
    parameter int CHUNK_WIDTH = DEF_CHUNK_WIDTH
) (
    input  logic                  clk,
    input  logic                  rst,
    pipe_cla_subtractor_if.slave  bus
);

    localparam int NUM_STAGES = stage_count(ADDER_WIDTH, CHUNK_WIDTH);
    localparam bit WIDTH_OK   = width_divides(ADDER_WIDTH, CHUNK_WIDTH);

    if (!WIDTH_OK) begin : g_bad_width
        $error("pipe_cla_subtractor: ADDER_WIDTH must be a multiple of CHUNK_WIDTH");
    end

    logic advance;

    assign advance = !g_stage[NUM_STAGES-1].v_q || bus.out_ready;

    // Stage s consumes the low slice of the operand bits still pending and appends its
    // sum above the slices already resolved, so every register is exactly as wide as
    // the data it still has to carry.
    for (genvar s = 0; s < NUM_STAGES; s++) begin : g_stage
        localparam int OPD_W = (NUM_STAGES - s) * CHUNK_WIDTH;
        localparam int RES_W = (s + 1) * CHUNK_WIDTH;

        logic [OPD_W-1:0]       a_in;
        logic [OPD_W-1:0]       b_in;
        logic                   cin;
        logic                   v_in;
        logic [RES_W-1:0]       res_d;
        logic [CHUNK_WIDTH-1:0] sum;
        logic                   cout;
        logic                   v_q;
        logic                   brw_q;
        logic [RES_W-1:0]       res_q;

        if (s == 0) begin : g_head
            assign a_in  = bus.a;
            assign b_in  = bus.b;
            assign cin   = ~bus.bin;
            assign v_in  = bus.in_valid;
            assign res_d = sum;
        end else begin : g_body
            assign a_in  = g_stage[s-1].g_fwd.a_fwd_q;
            assign b_in  = g_stage[s-1].g_fwd.b_fwd_q;
            assign cin   = ~g_stage[s-1].brw_q;
            assign v_in  = g_stage[s-1].v_q;
            assign res_d = {sum, g_stage[s-1].res_q};
        end

        pipe_cla_subtractor_sub_chunk_stage #(
            .CHUNK_WIDTH (CHUNK_WIDTH)
        ) u_chunk (
            .a_slice (a_in[CHUNK_WIDTH-1:0]),
            .b_slice (b_in[CHUNK_WIDTH-1:0]),
            .cin     (cin),
            .sum     (sum),
            .cout    (cout)
        );

        // Borrow is held inverted so that a cleared register reads as "no borrow".
        always_ff @(posedge clk) begin
            if (rst) begin
                v_q   <= 1'b0;
                brw_q <= 1'b0;
                res_q <= '0;
            end else if (advance) begin
                v_q   <= v_in;
                brw_q <= ~cout;
                res_q <= res_d;
            end
        end

        if (s < NUM_STAGES - 1) begin : g_fwd
            logic [OPD_W-CHUNK_WIDTH-1:0] a_fwd_q;
            logic [OPD_W-CHUNK_WIDTH-1:0] b_fwd_q;

            always_ff @(posedge clk) begin
                if (rst) begin
                    a_fwd_q <= '0;
                    b_fwd_q <= '0;
                end else if (advance) begin
                    a_fwd_q <= a_in[OPD_W-1:CHUNK_WIDTH];
                    b_fwd_q <= b_in[OPD_W-1:CHUNK_WIDTH];
                end
            end
        end
    end

    assign bus.in_ready  = advance;
    assign bus.out_valid = g_stage[NUM_STAGES-1].v_q;
    assign bus.diff      = g_stage[NUM_STAGES-1].res_q;
    assign bus.bout      = g_stage[NUM_STAGES-1].brw_q;
    assign bus.zero      = (g_stage[NUM_STAGES-1].res_q == '0);

endmodule

// File: tb/tb_pipe_cla_subtractor.sv
// Self-checking bench for pipe_cla_subtractor: directed steps plus random traffic,
// results scored against an arithmetic reference through an expected queue.
module tb_pipe_cla_subtractor;

    localparam int AW = 24;
    localparam int CW = 8;

    logic clk;
    logic rst;

    pipe_cla_subtractor_if #(.ADDER_WIDTH(AW)) bus ();

    pipe_cla_subtractor #(
        .ADDER_WIDTH (AW),
        .CHUNK_WIDTH (CW)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int unsigned n_cmp = 0;
    int unsigned n_bad = 0;
    logic [AW:0] exp_q[$];

    logic [AW-1:0] bp_a[5];
    logic [AW-1:0] bp_b[5];
    logic          bp_bin[5];
    logic [AW:0]   exp0;
    logic          pat_q[$];
    logic          iv;

    // ---------------- clock ----------------
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // ---------------- reference model ----------------
    // {bout, diff}: unsigned subtraction one bit wider; the extra bit is the borrow.
    function automatic logic [AW:0] ref_sub(input logic [AW-1:0] a, input logic [AW-1:0] b,
                                            input logic bin);
        logic [AW:0] r;
        r = {1'b0, a} - {1'b0, b} - (AW+1)'(bin);
        return r;
    endfunction

    function automatic logic [AW-1:0] pick();
        case ($urandom_range(0, 5))
            0:       return '0;
            1:       return '1;
            2:       return AW'(1);
            default: return AW'($urandom());
        endcase
    endfunction

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        assert (got === exp) else begin
            n_bad++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // ---------------- scoreboard ----------------
    always @(negedge clk) begin
        logic [AW:0] e;
        if (rst) begin
            exp_q.delete();
        end else begin
            if (bus.in_valid && bus.in_ready) begin
                exp_q.push_back(ref_sub(bus.a, bus.b, bus.bin));
            end
            if (bus.out_valid && bus.out_ready) begin
                check("sb_expected_present", 32'(exp_q.size() != 0), 32'd1);
                if (exp_q.size() != 0) begin
                    e = exp_q.pop_front();
                    check("sb_diff", 32'(bus.diff), 32'(e[AW-1:0]));
                    check("sb_bout", 32'(bus.bout), 32'(e[AW]));
                    check("sb_zero", 32'(bus.zero), 32'(e[AW-1:0] == '0));
                end
            end
        end
    end

    // ---------------- driver tasks ----------------
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic [AW-1:0] a, input logic [AW-1:0] b, input logic bin);
        bus.a        = a;
        bus.b        = b;
        bus.bin      = bin;
        bus.in_valid = 1'b1;
    endtask

    task automatic send_beat(input logic [AW-1:0] a, input logic [AW-1:0] b, input logic bin);
        logic acc;
        int   n;
        acc = 1'b0;
        n   = 0;
        drive(a, b, bin);
        while (!acc && n < 50) begin
            @(negedge clk);
            acc = bus.in_ready;
            step();
            n++;
        end
        check("send_accept", 32'(acc), 32'd1);
        bus.in_valid = 1'b0;
    endtask

    // Expects an empty pipe and out_ready = 1; checks the exact 3-edge latency.
    task automatic send_and_check(input logic [AW-1:0] a, input logic [AW-1:0] b,
                                  input logic bin, input logic [AW-1:0] ed,
                                  input logic eb, input logic ez, input string tag);
        drive(a, b, bin);
        step();
        bus.in_valid = 1'b0;
        @(negedge clk);
        check({tag, "_valid_e1"}, 32'(bus.out_valid), 32'd0);
        step();
        @(negedge clk);
        check({tag, "_valid_e2"}, 32'(bus.out_valid), 32'd0);
        step();
        @(negedge clk);
        check({tag, "_valid_e3"}, 32'(bus.out_valid), 32'd1);
        check({tag, "_diff"}, 32'(bus.diff), 32'(ed));
        check({tag, "_bout"}, 32'(bus.bout), 32'(eb));
        check({tag, "_zero"}, 32'(bus.zero), 32'(ez));
        step();
    endtask

    task automatic drain(input string tag);
        int n;
        n = 0;
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b1;
        while (exp_q.size() != 0 && n < 50) begin
            step();
            n++;
        end
        check(tag, 32'(exp_q.size()), 32'd0);
    endtask

    // ---------------- directed sequence ----------------
    initial begin
        rst           = 1'b1;
        bus.in_valid  = 1'b0;
        bus.a         = '0;
        bus.b         = '0;
        bus.bin       = 1'b0;
        bus.out_ready = 1'b1;
        step();
        step();
        rst = 1'b0;

        @(negedge clk);
        check("reset_out_valid", 32'(bus.out_valid), 32'd0);
        check("reset_diff", 32'(bus.diff), 32'd0);
        check("reset_bout", 32'(bus.bout), 32'd0);
        check("reset_zero", 32'(bus.zero), 32'd1);
        check("reset_in_ready", 32'(bus.in_ready), 32'd1);
        step();

        send_and_check(24'h000005, 24'h000003, 1'b0, 24'h000002, 1'b0, 1'b0, "basic");
        send_and_check(24'h000000, 24'h000001, 1'b0, 24'hFFFFFF, 1'b1, 1'b0, "ripple_neg");
        send_and_check(24'h100000, 24'h0FFFFF, 1'b1, 24'h000000, 1'b0, 1'b1, "ripple_zero");

        // Streaming sweep: difference is constant 0x2A1E minus the toggling borrow.
        bus.out_ready = 1'b1;
        for (int i = 0; i < 32768; i++) begin
            drive(AW'(3243579 + i), AW'(3232797 + i), ~i[0]);
            step();
        end
        drain("sweep_drain");

        // Backpressure: stall the output for 4 cycles with a beat waiting at the input.
        for (int i = 0; i < 5; i++) begin
            bp_a[i]   = pick();
            bp_b[i]   = pick();
            bp_bin[i] = 1'($urandom_range(0, 1));
        end
        exp0 = ref_sub(bp_a[0], bp_b[0], bp_bin[0]);
        for (int i = 0; i < 3; i++) begin
            drive(bp_a[i], bp_b[i], bp_bin[i]);
            step();
        end
        bus.out_ready = 1'b0;
        drive(bp_a[3], bp_b[3], bp_bin[3]);
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            check("stall_in_ready", 32'(bus.in_ready), 32'd0);
            check("stall_out_valid", 32'(bus.out_valid), 32'd1);
            check("stall_diff", 32'(bus.diff), 32'(exp0[AW-1:0]));
            check("stall_bout", 32'(bus.bout), 32'(exp0[AW]));
            step();
        end
        bus.out_ready = 1'b1;
        send_beat(bp_a[3], bp_b[3], bp_bin[3]);
        send_beat(bp_a[4], bp_b[4], bp_bin[4]);
        drain("stall_drain");

        // Bubbles: out_valid repeats the in_valid pattern three cycles later.
        pat_q = '{1'b0, 1'b0, 1'b0};
        for (int t = 0; t < 16; t++) begin
            iv = (t < 12) && ((t % 2) == 0);
            drive(pick(), pick(), 1'($urandom_range(0, 1)));
            bus.in_valid = iv;
            pat_q.push_back(iv);
            @(negedge clk);
            check("bubble_out_valid", 32'(bus.out_valid), 32'(pat_q.pop_front()));
            step();
        end
        drain("bubble_drain");

        // Reset with three beats in flight and a fourth presented during reset.
        for (int i = 0; i < 3; i++) begin
            drive(pick(), pick(), 1'($urandom_range(0, 1)));
            step();
        end
        drive(24'h000005, 24'h000003, 1'b0);
        rst = 1'b1;
        step();
        rst          = 1'b0;
        bus.in_valid = 1'b0;
        @(negedge clk);
        check("midrst_out_valid", 32'(bus.out_valid), 32'd0);
        check("midrst_diff", 32'(bus.diff), 32'd0);
        check("midrst_bout", 32'(bus.bout), 32'd0);
        check("midrst_zero", 32'(bus.zero), 32'd1);
        check("midrst_in_ready", 32'(bus.in_ready), 32'd1);
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            check("midrst_no_ghost", 32'(bus.out_valid), 32'd0);
        end
        step();
        send_and_check(24'h00ABCD, 24'h000BCD, 1'b1, 24'h009FFF, 1'b0, 1'b0, "post_rst");

        // Random traffic with random backpressure and boundary-heavy operands.
        for (int c = 0; c < 3000; c++) begin
            bus.a         = pick();
            bus.b         = pick();
            bus.bin       = 1'($urandom_range(0, 1));
            bus.in_valid  = ($urandom_range(0, 3) != 0);
            bus.out_ready = ($urandom_range(0, 3) != 0);
            step();
        end
        drain("random_drain");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
